// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial byte transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Width needed to hold a count from 0 up to n (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_tx_hold.sv
// One-entry holding buffer: valid/ready on the write side, full/pop on the
// read side. Ready is simply "not full", so a write and a pop never share a cycle.
module serial_tx_hold
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] out_data
);

    logic accept;

    assign accept   = in_valid & ~full;
    assign in_ready = ~full;

    // Capture the word only on acceptance; full tracks fill/drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_data <= '0;
        end else begin
            if (accept) begin
                out_data <= in_data;
            end
            full <= (full & ~pop) | accept;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Parallel-in / serial-out transmitter, LSB first, with a qualifying en_out
// strobe for a downstream right-shift register. Optional even parity bit
// after each word when SERIAL_TX_PARITY_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing on the wire; load from hold buffer when it fills
// SHIFT | one bit per cycle on dout with en_out high
// GAP   | en_out low for GAP_CYCLES cycles after a word
module serial_byte_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             en_out,
    output logic             word_done,
    output logic             busy
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int TOTAL_BITS = WIDTH + 1;
`else
    localparam int TOTAL_BITS = WIDTH;
`endif
    localparam int CW = cnt_width(TOTAL_BITS);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam logic [CW-1:0] LAST_CNT    = CW'(TOTAL_BITS);
    localparam logic [CW-1:0] LAST_M1_CNT = CW'(TOTAL_BITS - 1);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYCLES);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;  // bits already emitted for this word
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;  // idle cycles left, terminal count at 1
    logic             dout_d, en_d, done_d, busy_d;
    logic             hold_full, full_d, pop, accept;
    logic [WIDTH-1:0] hold_data;
    logic             load_now, emit_now, next_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    serial_tx_hold #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (load_data),
        .in_valid (load_valid),
        .in_ready (load_ready),
        .pop      (pop),
        .full     (hold_full),
        .out_data (hold_data)
    );

    assign accept = load_valid & load_ready;
    assign full_d = (hold_full & ~pop) | accept;

`ifdef SERIAL_TX_PARITY_EN
    // After the data bits the parity bit goes out in place of the shifter.
    assign next_bit = (bit_cnt_q == CW'(WIDTH)) ? parity_q : shreg_q[0];
`else
    assign next_bit = shreg_q[0];
`endif

    // Next-state and next-output decode; outputs are registered one step ahead.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        dout_d    = 1'b0;
        en_d      = 1'b0;
        done_d    = 1'b0;
        pop       = 1'b0;
        load_now  = 1'b0;
        emit_now  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    load_now = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_CNT) begin
                    emit_now = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (hold_full) begin
                    load_now = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q > GW'(1)) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end else if (hold_full) begin
                    load_now = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading emits bit0 on the same edge so a reload costs no bubble.
        if (load_now) begin
            pop       = 1'b1;
            state_d   = SHIFT;
            shreg_d   = hold_data >> 1;
            dout_d    = hold_data[0];
            en_d      = 1'b1;
            bit_cnt_d = CW'(1);
`ifdef SERIAL_TX_PARITY_EN
            parity_d  = ^hold_data;
`endif
        end
        if (emit_now) begin
            dout_d    = next_bit;
            en_d      = 1'b1;
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
            done_d    = (bit_cnt_q == LAST_M1_CNT);
        end
        busy_d = (state_d != IDLE) | full_d;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            dout      <= 1'b0;
            en_out    <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dout      <= dout_d;
            en_out    <= en_d;
            word_done <= done_d;
            busy      <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: two instances (no gap, 3-cycle gap), a bit-level
// scoreboard per instance and a model of the downstream right-shift register.
module tb_serial_byte_tx;

    localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int TOTAL = W + 1;
`else
    localparam int TOTAL = W;
`endif

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data0 = '0, data3 = '0;
    logic       valid0 = 1'b0, valid3 = 1'b0;
    logic       ready0, dout0, en0, done0, busy0;
    logic       ready3, dout3, en3, done3, busy3;
    logic [7:0] sh8;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q3[$];
    int   en_cnt0 = 0, run0 = 0, en_cnt3 = 0, run3 = 0, idle3 = 0;
    bit   had_run3 = 0;
    int   runs0[$];
    int   runs3[$];
    int   idles3[$];

    serial_byte_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_data(data0), .load_valid(valid0),
        .load_ready(ready0), .dout(dout0), .en_out(en0), .word_done(done0), .busy(busy0)
    );

    serial_byte_tx #(.WIDTH(W), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_data(data3), .load_valid(valid3),
        .load_ready(ready3), .dout(dout3), .en_out(en3), .word_done(done3), .busy(busy3)
    );

    initial forever #5 clk = ~clk;

    // Downstream register_right8: shifts din in at the MSB on each en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh8 <= '0;
        else if (en0) sh8 <= {dout0, sh8[7:1]};
    end

    function automatic void push_word(input int which, input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b = w[i];
            e.last = (i == TOTAL - 1);
            if (which == 0) q0.push_back(e); else q3.push_back(e);
        end
`ifdef SERIAL_TX_PARITY_EN
        e.b = ^w;
        e.last = 1'b1;
        if (which == 0) q0.push_back(e); else q3.push_back(e);
`endif
    endfunction

    function automatic void clear_stats();
        en_cnt0 = 0; run0 = 0; en_cnt3 = 0; run3 = 0; idle3 = 0; had_run3 = 0;
        runs0.delete(); runs3.delete(); idles3.delete();
    endfunction

    task automatic mon0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (en0) begin
                    en_cnt0++; run0++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL dut0_unexpected_bit got dout=%0b with empty scoreboard", dout0);
                    end else begin
                        e = q0.pop_front();
                        if (dout0 !== e.b || done0 !== e.last) begin
                            errors++;
                            $display("FAIL dut0_bit got dout=%0b done=%0b expected dout=%0b done=%0b",
                                     dout0, done0, e.b, e.last);
                        end
                    end
                end else begin
                    if (dout0 !== 1'b0 || done0 !== 1'b0) begin
                        errors++;
                        $display("FAIL dut0_idle_out got dout=%0b done=%0b expected 0 0", dout0, done0);
                    end
                    if (run0 > 0) runs0.push_back(run0);
                    run0 = 0;
                end
            end
        end
    endtask

    task automatic mon3();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (en3) begin
                    if (run3 == 0 && had_run3) idles3.push_back(idle3);
                    idle3 = 0;
                    en_cnt3++; run3++;
                    if (q3.size() == 0) begin
                        errors++;
                        $display("FAIL dut3_unexpected_bit got dout=%0b with empty scoreboard", dout3);
                    end else begin
                        e = q3.pop_front();
                        if (dout3 !== e.b || done3 !== e.last) begin
                            errors++;
                            $display("FAIL dut3_bit got dout=%0b done=%0b expected dout=%0b done=%0b",
                                     dout3, done3, e.b, e.last);
                        end
                    end
                end else begin
                    if (dout3 !== 1'b0 || done3 !== 1'b0) begin
                        errors++;
                        $display("FAIL dut3_idle_out got dout=%0b done=%0b expected 0 0", dout3, done3);
                    end
                    if (run3 > 0) begin
                        runs3.push_back(run3);
                        had_run3 = 1;
                    end
                    run3 = 0;
                    idle3++;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int which, input logic [7:0] w, output bit ok);
        int n = 0;
        ok = 0;
        if (which == 0) begin data0 = w; valid0 = 1'b1; end
        else begin data3 = w; valid3 = 1'b1; end
        while (n < 100) begin
            if (((which == 0) ? ready0 : ready3) === 1'b1) begin
                @(posedge clk);
                push_word(which, w);
                ok = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (which == 0) valid0 = 1'b0; else valid3 = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q3.size() == 0 && !en0 && !en3 && !busy0 && !busy3) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready0, dout0, en0, done0, busy0} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_hold_dut0 got %b expected 10000", {ready0, dout0, en0, done0, busy0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready0, dout0, en0, done0, busy0} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_dut0 got %b expected 10000", {ready0, dout0, en0, done0, busy0});
        end
        checks++;
        if ({ready3, dout3, en3, done3, busy3} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_dut3 got %b expected 10000", {ready3, dout3, en3, done3, busy3});
        end
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk);
        clear_stats();
        send(0, 8'hE2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_send timeout got none expected accept"); end
        checks++;
        if (en0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL single_lat1 got en=%0b busy=%0b expected en=0 busy=1", en0, busy0);
        end
        @(negedge clk);
        checks++;
        if (en0 !== 1'b1 || dout0 !== 1'b0) begin
            errors++;
            $display("FAIL single_lat2 got en=%0b dout=%0b expected en=1 dout=0", en0, dout0);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain timeout got busy expected idle"); end
        checks++;
        if (runs0.size() != 1 || en_cnt0 != TOTAL) begin
            errors++;
            $display("FAIL single_runs got runs=%0d en=%0d expected 1 %0d", runs0.size(), en_cnt0, TOTAL);
        end
`ifndef SERIAL_TX_PARITY_EN
        checks++;
        if (sh8 !== 8'hE2) begin
            errors++;
            $display("FAIL downstream_pa got %h expected e2", sh8);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok;
        int n = 0;
        @(negedge clk);
        clear_stats();
        send(0, 8'hE2, ok1);
        send(0, 8'h5A, ok2);
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_send timeout got none expected accept"); end
        while (ready0 === 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TOTAL - 1) begin
            errors++;
            $display("FAIL b2b_ready_low got %0d cycles expected %0d", n, TOTAL - 1);
        end
        wait_idle(ok);
        checks++;
        if (!ok || runs0.size() != 1 || runs0[0] != 2 * TOTAL) begin
            errors++;
            $display("FAIL b2b_stream got runs=%0d first=%0d expected 1 run of %0d",
                     runs0.size(), (runs0.size() > 0) ? runs0[0] : -1, 2 * TOTAL);
        end
    endtask

    task automatic test_gap();
        bit ok1, ok2, ok;
        @(negedge clk);
        clear_stats();
        send(1, 8'hE2, ok1);
        send(1, 8'h5A, ok2);
        wait_idle(ok);
        checks++;
        if (!(ok1 && ok2 && ok)) begin errors++; $display("FAIL gap_flow timeout got stall expected drain"); end
        checks++;
        if (runs3.size() != 2 || runs3[0] != TOTAL || runs3[1] != TOTAL) begin
            errors++;
            $display("FAIL gap_bursts got %0d bursts expected 2 of %0d", runs3.size(), TOTAL);
        end
        checks++;
        if (idles3.size() != 1 || idles3[0] != 3) begin
            errors++;
            $display("FAIL gap_len got count=%0d len=%0d expected 1 gap of 3",
                     idles3.size(), (idles3.size() > 0) ? idles3[0] : -1);
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok1, ok2;
        int n = 0;
        @(negedge clk);
        clear_stats();
        send(0, 8'hFF, ok1);
        send(0, 8'hA5, ok2);
        while (en_cnt0 < 4 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (!(ok1 && ok2) || en_cnt0 != 4) begin
            errors++;
            $display("FAIL midrst_setup got bits=%0d expected 4", en_cnt0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (en0 !== 1'b0 || ready0 !== 1'b1 || busy0 !== 1'b0 || dout0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got en=%0b ready=%0b busy=%0b dout=%0b expected 0 1 0 0",
                     en0, ready0, busy0, dout0);
        end
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (en_cnt0 != 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard got bits=%0d busy=%0b expected 0 0", en_cnt0, busy0);
        end
    endtask

    task automatic test_data_stability();
        bit ok1, ok2, ok, acc = 0;
        @(negedge clk);
        clear_stats();
        send(0, 8'h3C, ok1);
        send(0, 8'hC3, ok2);
        valid0 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            data0 = 8'($urandom);
            if (ready0 === 1'b1) begin
                @(posedge clk);
                push_word(0, data0);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        valid0 = 1'b0;
        repeat (3) begin
            data0 = 8'($urandom);
            @(negedge clk);
        end
        wait_idle(ok);
        checks++;
        if (!(ok1 && ok2 && acc && ok) || en_cnt0 != 3 * TOTAL) begin
            errors++;
            $display("FAIL stable_data got bits=%0d expected %0d", en_cnt0, 3 * TOTAL);
        end
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        bit ok1, ok2, ok;
        @(negedge clk);
        clear_stats();
        send(0, 8'hE2, ok1);
        wait_idle(ok);
        send(0, 8'h07, ok2);
        wait_idle(ok);
        checks++;
        if (!(ok1 && ok2 && ok) || runs0.size() != 2 || runs0[0] != 9 || runs0[1] != 9) begin
            errors++;
            $display("FAIL parity_len got %0d bursts expected 2 of 9", runs0.size());
        end
    endtask
`endif

    initial begin
        fork
            mon0();
            mon3();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_reset_mid_word();
        test_data_stability();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
